// File: rtl/calc_n_port.sv
`default_nettype none
// ============================================================================
// Module : calc_n_port
// Multi-port calculator: N requester ports share one two-stage ALU through a
// round-robin arbiter; each port runs its own request/response FSM.
// Rev    : 1.0  initial release
// ============================================================================
module calc_n_port #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int CMD_W     = 4
) (
    input  logic                        c_clk,
    input  logic                        reset,
    input  logic [NUM_PORTS*CMD_W-1:0]  req_cmd_in,
    input  logic [NUM_PORTS*DATA_W-1:0] req_data_in,
    output logic [NUM_PORTS*2-1:0]      out_resp,
    output logic [NUM_PORTS*DATA_W-1:0] out_data,
    output logic [NUM_PORTS-1:0]        port_busy
);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    localparam logic [CMD_W-1:0] CMD_ADD = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_SUB = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_SHL = CMD_W'(5);
    localparam logic [CMD_W-1:0] CMD_SHR = CMD_W'(6);

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OP2  = 3'd1,
        ST_PEND = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t            state_q [NUM_PORTS];
    state_t            state_d [NUM_PORTS];
    logic [CMD_W-1:0]  cmd_q   [NUM_PORTS];
    logic [CMD_W-1:0]  cmd_d   [NUM_PORTS];
    logic [DATA_W-1:0] op1_q   [NUM_PORTS];
    logic [DATA_W-1:0] op1_d   [NUM_PORTS];
    logic [DATA_W-1:0] op2_q   [NUM_PORTS];
    logic [DATA_W-1:0] op2_d   [NUM_PORTS];
    logic [1:0]        resp_q  [NUM_PORTS];
    logic [1:0]        resp_d  [NUM_PORTS];
    logic [DATA_W-1:0] data_q  [NUM_PORTS];
    logic [DATA_W-1:0] data_d  [NUM_PORTS];

    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic              gnt_valid;
    logic [PTR_W-1:0]  gnt_idx;
    logic [PTR_W-1:0]  cand;
    int                cand_i;

    logic              s1_valid_q, s1_valid_d;
    logic [PTR_W-1:0]  s1_port_q, s1_port_d;
    logic [CMD_W-1:0]  s1_cmd_q, s1_cmd_d;
    logic [DATA_W-1:0] s1_op1_q, s1_op1_d;
    logic [DATA_W-1:0] s1_op2_q, s1_op2_d;

    logic [DATA_W:0]   alu_sum;
    logic [1:0]        alu_resp;
    logic [DATA_W-1:0] alu_data;

    // Round-robin search over PEND ports, starting at the pointer.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        cand_i    = 0;
        cand      = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand_i = int'(ptr_q) + k;
            if (cand_i >= NUM_PORTS) cand_i = cand_i - NUM_PORTS;
            cand = PTR_W'(cand_i);
            if (!gnt_valid && state_q[cand] == ST_PEND) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand;
            end
        end
        ptr_d = ptr_q;
        if (gnt_valid)
            ptr_d = (int'(gnt_idx) == NUM_PORTS - 1) ? '0 : gnt_idx + PTR_W'(1);
    end

    always_comb begin
        s1_valid_d = gnt_valid;
        s1_port_d  = gnt_idx;
        s1_cmd_d   = cmd_q[gnt_idx];
        s1_op1_d   = op1_q[gnt_idx];
        s1_op2_d   = op2_q[gnt_idx];
    end

    always_comb begin
        alu_sum  = {1'b0, s1_op1_q} + {1'b0, s1_op2_q};
        alu_resp = RESP_ERR;
        alu_data = '0;
        case (s1_cmd_q)
            CMD_ADD: if (!alu_sum[DATA_W]) begin
                alu_resp = RESP_OK;
                alu_data = alu_sum[DATA_W-1:0];
            end
            CMD_SUB: if (s1_op2_q <= s1_op1_q) begin
                alu_resp = RESP_OK;
                alu_data = s1_op1_q - s1_op2_q;
            end
            CMD_SHL: begin
                alu_resp = RESP_OK;
                alu_data = s1_op1_q << s1_op2_q[SH_W-1:0];
            end
            CMD_SHR: begin
                alu_resp = RESP_OK;
                alu_data = s1_op1_q >> s1_op2_q[SH_W-1:0];
            end
            default: ;
        endcase
    end

    // Response registers default to zero so outputs are only nonzero in DONE.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            state_d[i] = state_q[i];
            cmd_d[i]   = cmd_q[i];
            op1_d[i]   = op1_q[i];
            op2_d[i]   = op2_q[i];
            resp_d[i]  = RESP_NONE;
            data_d[i]  = '0;
            case (state_q[i])
                ST_IDLE: if (req_cmd_in[i*CMD_W +: CMD_W] != '0) begin
                    cmd_d[i]   = req_cmd_in[i*CMD_W +: CMD_W];
                    op1_d[i]   = req_data_in[i*DATA_W +: DATA_W];
                    state_d[i] = ST_OP2;
                end
                ST_OP2: begin
                    op2_d[i]   = req_data_in[i*DATA_W +: DATA_W];
                    state_d[i] = ST_PEND;
                end
                ST_PEND: if (gnt_valid && gnt_idx == PTR_W'(i)) state_d[i] = ST_WAIT;
                ST_WAIT: if (s1_valid_q && s1_port_q == PTR_W'(i)) begin
                    state_d[i] = ST_DONE;
                    resp_d[i]  = alu_resp;
                    data_d[i]  = alu_data;
                end
                ST_DONE: state_d[i] = ST_IDLE;
                default: state_d[i] = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge c_clk or negedge reset) begin
        if (!reset) begin
            ptr_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_port_q  <= '0;
            s1_cmd_q   <= '0;
            s1_op1_q   <= '0;
            s1_op2_q   <= '0;
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= ST_IDLE;
                cmd_q[i]   <= '0;
                op1_q[i]   <= '0;
                op2_q[i]   <= '0;
                resp_q[i]  <= RESP_NONE;
                data_q[i]  <= '0;
            end
        end else begin
            ptr_q      <= ptr_d;
            s1_valid_q <= s1_valid_d;
            s1_port_q  <= s1_port_d;
            s1_cmd_q   <= s1_cmd_d;
            s1_op1_q   <= s1_op1_d;
            s1_op2_q   <= s1_op2_d;
            for (int i = 0; i < NUM_PORTS; i++) begin
                state_q[i] <= state_d[i];
                cmd_q[i]   <= cmd_d[i];
                op1_q[i]   <= op1_d[i];
                op2_q[i]   <= op2_d[i];
                resp_q[i]  <= resp_d[i];
                data_q[i]  <= data_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port_out
        assign out_resp[g*2 +: 2]           = resp_q[g];
        assign out_data[g*DATA_W +: DATA_W] = data_q[g];
        assign port_busy[g]                 = (state_q[g] != ST_IDLE);
    end

endmodule
`default_nettype wire

// File: tb/tb_calc_n_port.sv
`default_nettype none
// ============================================================================
// Module : tb_calc_n_port
// Scoreboard bench for calc_n_port (4 ports, 32-bit data).
// Rev    : 1.0  initial release
// ============================================================================
module tb_calc_n_port;
    localparam int NP = 4;
    localparam int DW = 32;
    localparam int CW = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP*CW-1:0]  req_cmd;
    logic [NP*DW-1:0]  req_data;
    logic [NP*2-1:0]   resp;
    logic [NP*DW-1:0]  data;
    logic [NP-1:0]     busy;

    calc_n_port #(.NUM_PORTS(NP), .DATA_W(DW), .CMD_W(CW)) dut (
        .c_clk       (clk),
        .reset       (rst_n),
        .req_cmd_in  (req_cmd),
        .req_data_in (req_data),
        .out_resp    (resp),
        .out_data    (data),
        .port_busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         port;
        logic [1:0] resp;
        logic [31:0] data;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [33:0] model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        longint unsigned s;
        case (c)
            4'd1: begin
                s = longint'(a) + longint'(b);
                if (s > 64'h0000_0000_FFFF_FFFF) return {2'd2, 32'd0};
                return {2'd1, s[31:0]};
            end
            4'd2: return (b > a) ? {2'd2, 32'd0} : {2'd1, a - b};
            4'd5: return {2'd1, a << b[4:0]};
            4'd6: return {2'd1, a >> b[4:0]};
            default: return {2'd2, 32'd0};
        endcase
    endfunction

    task automatic push(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input int due);
        logic [33:0] m;
        m = model(c, a, b);
        sb.push_back('{port: p, resp: m[33:32], data: m[31:0], due: due});
    endtask

    task automatic start(input int p, input logic [3:0] c, input logic [31:0] a);
        req_cmd[p*CW +: CW]  = c;
        req_data[p*DW +: DW] = a;
    endtask

    task automatic second(input int p, input logic [31:0] b);
        req_cmd[p*CW +: CW]  = '0;
        req_data[p*DW +: DW] = b;
    endtask

    task automatic clear(input int p);
        req_cmd[p*CW +: CW]  = '0;
        req_data[p*DW +: DW] = '0;
    endtask

    task automatic wait_idle(input int p);
        int k;
        k = 0;
        while (busy[p] && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (busy[p]) check_val("idle_timeout", {63'd0, busy[p]}, 64'd0);
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 60) begin
            @(negedge clk);
            #1;
            k++;
        end
        check_val("drain", sb.size(), 64'd0);
    endtask

    // Uncontended request; response expected at minimum latency.
    task automatic single(input int p, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        push(p, c, a, b, cyc + 4);
        start(p, c, a);
        @(negedge clk);
        second(p, b);
        @(negedge clk);
        clear(p);
        wait_idle(p);
    endtask

    // Response monitor: every nonzero response must match the oldest entry for that port.
    always @(negedge clk) begin
        int         nresp;
        int         hit;
        logic [1:0] r;
        logic [31:0] d;
        nresp = 0;
        for (int p = 0; p < NP; p++) begin
            r = resp[p*2 +: 2];
            d = data[p*DW +: DW];
            if (r != 2'd0) begin
                nresp++;
                hit = -1;
                for (int j = 0; j < sb.size(); j++)
                    if (hit < 0 && sb[j].port == p) hit = j;
                if (hit < 0) begin
                    check_val($sformatf("unexpected_resp_p%0d", p), {62'd0, r}, 64'd0);
                end else begin
                    check_val($sformatf("resp_p%0d", p), {62'd0, r}, {62'd0, sb[hit].resp});
                    check_val($sformatf("data_p%0d", p), {32'd0, d}, {32'd0, sb[hit].data});
                    if (sb[hit].due >= 0)
                        check_val($sformatf("latency_p%0d", p), cyc, sb[hit].due);
                    sb.delete(hit);
                end
            end else begin
                check_val($sformatf("idle_data_p%0d", p), {32'd0, d}, 64'd0);
            end
        end
        check_val("one_resp_per_cycle", {63'd0, nresp > 1}, 64'd0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n    = 1'b0;
        req_cmd  = '0;
        req_data = '0;
        repeat (3) @(negedge clk);
        check_val("rst_resp", {56'd0, resp}, 64'd0);
        check_val("rst_data", {{(128-NP*DW){1'b0}}, data} == '0, 64'd1);
        check_val("rst_busy", {60'd0, busy}, 64'd0);

        // All ports issue on the first edge after reset release.
        rst_n = 1'b1;
        for (int p = 0; p < NP; p++) begin
            push(p, 4'd1, p, 10, cyc + 4 + p);
            start(p, 4'd1, p);
        end
        @(negedge clk);
        for (int p = 0; p < NP; p++) second(p, 10);
        @(negedge clk);
        for (int p = 0; p < NP; p++) clear(p);
        wait_drain();

        // Second simultaneous round: pointer wrapped back to port 0.
        @(negedge clk);
        for (int p = 0; p < NP; p++) begin
            push(p, 4'd1, p, 10, cyc + 4 + p);
            start(p, 4'd1, p);
        end
        @(negedge clk);
        for (int p = 0; p < NP; p++) second(p, 10);
        @(negedge clk);
        for (int p = 0; p < NP; p++) clear(p);
        wait_drain();

        // Port 0 basic add with busy tracking.
        @(negedge clk);
        push(0, 4'd1, 32'h0000_0001, 32'h1FFF_FFFF, cyc + 4);
        start(0, 4'd1, 32'h0000_0001);
        @(negedge clk);
        second(0, 32'h1FFF_FFFF);
        check_val("t1_busy_op2", {63'd0, busy[0]}, 64'd1);
        repeat (3) begin
            @(negedge clk);
            clear(0);
            check_val("t1_busy", {63'd0, busy[0]}, 64'd1);
        end
        @(negedge clk);
        check_val("t1_busy_fall", {63'd0, busy[0]}, 64'd0);

        // Port 1 overflow / underflow / normal subtract.
        single(1, 4'd1, 32'hFFFF_FFFF, 32'h1);
        single(1, 4'd2, 32'h1, 32'hF);
        single(1, 4'd2, 32'hF, 32'h1);
        single(1, 4'd2, 32'h1234, 32'h1234);

        // Port 2 shifts and invalid commands.
        single(2, 4'd5, 32'h1, 32'd31);
        single(2, 4'd6, 32'h8000_0000, 32'd33);
        single(2, 4'd6, 32'hF0F0_F0F0, 32'd4);
        single(2, 4'd3, 32'h5, 32'h6);
        single(2, 4'd4, 32'h5, 32'h6);
        single(2, 4'd15, 32'h5, 32'h6);
        wait_drain();

        // Port 3: commands while busy are dropped.
        @(negedge clk);
        push(3, 4'd1, 32'd5, 32'd6, cyc + 4);
        start(3, 4'd1, 32'd5);
        @(negedge clk);
        second(3, 32'd6);
        @(negedge clk);
        check_val("t5_busy", {63'd0, busy[3]}, 64'd1);
        start(3, 4'd1, 32'd100);
        @(negedge clk);
        start(3, 4'd2, 32'd200);
        @(negedge clk);
        start(3, 4'd1, 32'd300);
        @(negedge clk);
        clear(3);
        wait_idle(3);
        repeat (6) @(negedge clk);
        check_val("t5_single_resp", sb.size(), 64'd0);

        // Reset while ports 0 and 1 are pending and port 2 is in DONE.
        @(negedge clk);
        push(2, 4'd1, 32'd7, 32'd8, cyc + 4);
        start(2, 4'd1, 32'd7);
        @(negedge clk);
        second(2, 32'd8);
        @(negedge clk);
        clear(2);
        start(0, 4'd1, 32'd40);
        start(1, 4'd1, 32'd50);
        @(negedge clk);
        second(0, 32'd1);
        second(1, 32'd1);
        @(negedge clk);
        clear(0);
        clear(1);
        check_val("t6_busy_pre", {62'd0, busy[1:0]}, 64'd3);
        check_val("t6_resp2_pre", {62'd0, resp[5:4]}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6_rst_resp", {56'd0, resp}, 64'd0);
        check_val("t6_rst_data", {63'd0, data == '0}, 64'd1);
        check_val("t6_rst_busy", {60'd0, busy}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check_val("t6_no_stale", sb.size(), 64'd0);

        // Ports 1 and 3 together after reset: pointer restarted at 0.
        @(negedge clk);
        push(1, 4'd1, 32'd2, 32'd3, cyc + 4);
        push(3, 4'd1, 32'd9, 32'd9, cyc + 5);
        start(1, 4'd1, 32'd2);
        start(3, 4'd1, 32'd9);
        @(negedge clk);
        second(1, 32'd3);
        second(3, 32'd9);
        @(negedge clk);
        clear(1);
        clear(3);
        wait_drain();

        repeat (4) @(negedge clk);
        check_val("sb_empty", sb.size(), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/calc_n_port.md
Name: calc_n_port

Overview:
- Next-generation multi-port calculator, successor to the fixed four-port calc1.
- Port count and data width are parametrised; adds logical shift commands.
- Requesters share one pipelined ALU through a round-robin arbiter and get a per-port busy indication.
- Sits between the requester ports and their response consumers, exactly where calc1 sits.

Parameters:
- NUM_PORTS, 4, number of requester ports (1..16).
- DATA_W, 32, operand/result width (power of two, 8..64).
- CMD_W, 4, command field width.

Ports:
- c_clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- req_cmd_in  input  NUM_PORTS*CMD_W  per-port command; port i at bits [i*CMD_W +: CMD_W].
- req_data_in  input  NUM_PORTS*DATA_W  per-port operand; port i at bits [i*DATA_W +: DATA_W].
- out_resp  output  NUM_PORTS*2  per-port response code; port i at bits [i*2 +: 2].
- out_data  output  NUM_PORTS*DATA_W  per-port result.
- port_busy  output  NUM_PORTS  1 = port has a request in flight; new commands on that port are ignored.

Behaviour:
- Commands: 0 no-op; 1 add; 2 sub; 5 shift left logical; 6 shift right logical; all other codes invalid.
- Response codes: 0 none; 1 success; 2 error (overflow, underflow or invalid command); 3 never driven.
- Request protocol: cycle T carries nonzero cmd with op1 on data; cycle T+1 carries op2 on data (cmd value in T+1 ignored).
- Per-port FSM states:
  - IDLE: nonzero cmd captures cmd and op1, go to OP2.
  - OP2: capture op2, go to PEND.
  - PEND: wait for grant; on grant go to WAIT.
  - WAIT: on ALU result go to DONE.
  - DONE: drive resp/data for one cycle, go to IDLE.
- port_busy = 1 in every state except IDLE. Busy rises the cycle after the cmd is accepted and falls the cycle after DONE.
- Commands presented while busy are dropped silently.
- A port may issue a new cmd in the first cycle it is back in IDLE.
- Arbiter: one grant per cycle among PEND ports, round-robin. Search starts at pointer; after a grant, pointer = grantee+1 mod NUM_PORTS. Pointer does not move when there are no requests.
- ALU pipeline: grant cycle G registers operands; G+1 computes and registers the result; the port is in DONE and drives outputs in G+2.
- Minimum latency: response 3 cycles after the op2 cycle (PEND at T+2, grant at T+2, response at T+4).
- Arithmetic is unsigned, DATA_W bits:
  - add: carry out gives resp 2, data 0; otherwise resp 1, data = sum.
  - sub: op2 > op1 gives resp 2, data 0; otherwise resp 1, data = op1-op2 (equal operands give 0, resp 1).
  - shifts: amount = op2[log2(DATA_W)-1:0], upper op2 bits ignored, zeros fill vacated bits, always resp 1.
  - invalid cmd: still consumes an ALU slot; resp 2, data 0.
- Outputs: out_resp and out_data are 0 on every port in every cycle except that port's DONE cycle.
- Simultaneous events:
  - Any number of ports may enter PEND in the same cycle; they are served one per cycle in round-robin order.
  - Responses on different ports can therefore coincide only if they were granted in the same cycle, which never happens.
- Reset (reset = 0), asynchronous, takes effect immediately:
  - all outputs 0, all FSMs IDLE, pointer 0, pipeline cleared.
  - in-flight requests are lost and never answered.
  - the first command is accepted on the first rising edge with reset = 1.

Test Plan:
1. Port 0: cmd 1, data 0x0000_0001, then 0x1FFF_FFFF, no contention -> port 0 resp 1, data 0x2000_0000 exactly 3 cycles after the op2 cycle; port_busy[0] high throughout; other ports resp 0.
2. Port 1: add 0xFFFF_FFFF + 0x1 -> resp 2, data 0. Sub 0x1 - 0xF -> resp 2, data 0. Sub 0xF - 0x1 -> resp 1, data 0xE.
3. All 4 ports issue add (op1 = i, op2 = 10) in the same cycles from reset -> responses on ports 0, 1, 2, 3 in four consecutive cycles with data 10, 11, 12, 13. Immediate second round from all ports -> served again starting at port 0 (pointer wrapped from 3).
4. Port 2: shl 0x1 by 31 -> 0x8000_0000, resp 1. shr 0x8000_0000 by 33 -> 0x4000_0000 (amount uses low 5 bits = 1). cmd 3 -> resp 2, data 0. cmd 4 -> resp 2, data 0.
5. Port 3 sends a second nonzero cmd while port_busy[3] = 1 -> ignored: exactly one response, matching the first request.
6. Assert reset while ports 0 and 1 are in PEND -> all outputs 0 within the same cycle, busy cleared, no responses after release. A new add 2+3 on port 1 after release -> resp 1, data 5 with minimum latency.
